refresh_timeout_timer: RTL
==========================

Name: refresh_timeout_timer

Overview:
- Timing source that sits directly upstream of the FSB controller and the DRAM controller.
- Generates DRAM refresh requests: a periodic tick feeds a pending-refresh debt counter, which drives RefReq/RefUrgent and is retired by RefAck.
- Measures FSB bus-cycle duration from ASActive and produces TimeoutA (short, sound-RAM write completion) and TimeoutB (long, bus-error timeout).
- All logic in the CLK_FSB domain; outputs feed the FSB and RAM blocks unchanged.

Parameters:
- REF_PERIOD, 375, CLK_FSB cycles between refresh ticks (15 us at 25 MHz).
- REF_URGENT, 2, pending count at or above which RefUrgent asserts.
- REF_MAX, 7, saturation value of the pending counter.
- TOA_CYC, 16, cycles of continuous ASActive before TimeoutA.
- TOB_CYC, 256, cycles of continuous ASActive before TimeoutB (TOB_CYC > TOA_CYC).

Ports:
- CLK_FSB  in  1  FSB clock.
- nRES  in  1  reset, asynchronous assert, active-low.
- ASActive  in  1  synchronized AS-active level from FSB.
- RefAck  in  1  one-cycle pulse: one refresh completed.
- RefReq  out  1  at least one refresh pending.
- RefUrgent  out  1  pending >= REF_URGENT.
- TimeoutA  out  1  bus cycle exceeded TOA_CYC.
- TimeoutB  out  1  bus cycle exceeded TOB_CYC.

Behaviour:
- Reset: clock and reset are decided as one clock, CLK_FSB; reset nRES is asynchronous and active-low. While nRES is low: all counters 0, FSM in IDLE, all outputs 0. After release, the prescaler starts from 0.
- Tick: the prescaler counts 0..REF_PERIOD-1 and wraps. A one-cycle tick fires on the wrap cycle, so the first tick comes REF_PERIOD cycles after reset release.
- Pending counter, width $clog2(REF_MAX+1), updated each cycle:
  - tick only: +1.
  - RefAck only: -1.
  - tick and RefAck together: unchanged.
  - tick at REF_MAX: stays at REF_MAX and the tick is lost.
  - RefAck at 0: ignored, no underflow.
- RefReq = (pending != 0). RefUrgent = (pending >= REF_URGENT). Both are registered outputs: they reflect the counter value of the previous edge, one cycle of latency.
- Timeout FSM states: IDLE, COUNT, EXPA, EXPB. The cycle counter saturates at TOB_CYC.
  - IDLE: counter = 0. ASActive=1 -> COUNT with counter = 1.
  - COUNT: counter +1 per cycle. Counter reaches TOA_CYC -> EXPA.
  - EXPA: TimeoutA=1. Counter reaches TOB_CYC -> EXPB.
  - EXPB: TimeoutA=1, TimeoutB=1, held.
  - Any state, ASActive=0 -> IDLE, counter cleared, both timeouts 0 on the next edge.
- Timeouts are registered. TimeoutA first asserts on the edge where the count equals TOA_CYC, i.e. after TOA_CYC cycles of ASActive high.
- Back-to-back cycles: ASActive low for a single cycle fully resets the measurement.
- The refresh path and the timeout path are independent. Refresh continues during bus cycles.

Optional Feature:
- Macro REF_OVERFLOW_EN.
- Defined: adds output RefOverflow (1 bit). It is a sticky flag set when a tick arrives while pending == REF_MAX and RefAck is 0. It clears only on nRES; reset value 0.
- Undefined: no port and no flag logic; the saturated tick is silently dropped.

Decomposition:
- Shared package: default constants REF_PERIOD_DEF, REF_URGENT_DEF, REF_MAX_DEF, TOA_CYC_DEF, TOB_CYC_DEF, and the timeout FSM state enum (IDLE, COUNT, EXPA, EXPB), so the FSB and RAM benches reuse them.
- One sub-module: ref_tick_gen, the REF_PERIOD prescaler with a one-cycle tick output, async active-low reset. The pending counter and timeout FSM stay in the top module.

Test Plan:
- Release reset, no RefAck -> tick at cycle 375 sets RefReq=1 at 376. RefUrgent=1 one cycle after the second tick (cycle 751). Pending saturates at 7 after 7 ticks; with REF_OVERFLOW_EN, RefOverflow=1 after the 8th tick.
- Pending=1, RefAck pulsed on the same cycle as a tick -> pending stays 1, RefReq remains 1. Then RefAck alone -> RefReq=0 next cycle.
- RefAck with pending=0 -> pending stays 0, RefReq=0, no wrap to 7.
- ASActive held high 300 cycles -> TimeoutA=1 from cycle 16, TimeoutB=1 from cycle 256. Both drop one cycle after ASActive falls.
- ASActive high 10 cycles, low 1 cycle, high 10 cycles -> TimeoutA never asserts.
- nRES asserted mid-cycle with pending=3 and FSM in EXPA -> all outputs 0 immediately (asynchronous). After release, RefReq stays 0 until the first tick at 375.

Source files
------------

// File: rtl/refresh_timeout_timer_pkg.sv
// Shared constants and the timeout FSM state type for the refresh/timeout timer.
// The FSB and RAM benches reuse the default constants from here.
package refresh_timeout_timer_pkg;

    localparam int REF_PERIOD_DEF = 375;   // CLK_FSB cycles per refresh tick (15 us at 25 MHz)
    localparam int REF_URGENT_DEF = 2;     // pending count that raises RefUrgent
    localparam int REF_MAX_DEF    = 7;     // pending counter saturation value
    localparam int TOA_CYC_DEF    = 16;    // short timeout (sound-RAM write completion)
    localparam int TOB_CYC_DEF    = 256;   // long timeout (bus error)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EXPA  = 2'd2,
        EXPB  = 2'd3
    } to_state_e;

endpackage

// File: rtl/refresh_timeout_timer_tick_gen.sv
// Refresh prescaler: counts 0..PERIOD-1 from reset release and emits a
// one-cycle tick on the wrap cycle, so the first tick lands PERIOD cycles
// after reset is released.
module ref_tick_gen
    import refresh_timeout_timer_pkg::*;
#(
    parameter int PERIOD = REF_PERIOD_DEF
) (
    input  logic clk_sys,
    input  logic rst_n,
    output logic tick
);

    localparam int             CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Free-running prescaler, wraps at PERIOD-1.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/refresh_timeout_timer.sv
// DRAM refresh request generator and FSB bus-cycle timeout timer.
// Optional build macro REF_OVERFLOW_EN adds the sticky RefOverflow output,
// which records a refresh tick lost to a saturated pending counter.
//
// Timeout FSM:
//   state | meaning
//   IDLE  | no bus cycle active, counter 0
//   COUNT | bus cycle active, below TOA_CYC
//   EXPA  | TOA_CYC reached, TimeoutA asserted
//   EXPB  | TOB_CYC reached, TimeoutA and TimeoutB held
module refresh_timeout_timer
    import refresh_timeout_timer_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_DEF,
    parameter int REF_URGENT = REF_URGENT_DEF,
    parameter int REF_MAX    = REF_MAX_DEF,
    parameter int TOA_CYC    = TOA_CYC_DEF,
    parameter int TOB_CYC    = TOB_CYC_DEF
) (
    input  logic CLK_FSB,
    input  logic nRES,
    input  logic ASActive,
    input  logic RefAck,
    output logic RefReq,
    output logic RefUrgent,
    output logic TimeoutA,
    output logic TimeoutB
`ifdef REF_OVERFLOW_EN
    ,
    output logic RefOverflow
`endif
);

    localparam int            PW       = $clog2(REF_MAX + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(REF_MAX);
    localparam logic [PW-1:0] PEND_URG = PW'(REF_URGENT);

    localparam int            TW       = $clog2(TOB_CYC + 1);
    localparam logic [TW-1:0] TOA_LIM  = TW'(TOA_CYC);
    localparam logic [TW-1:0] TOB_LIM  = TW'(TOB_CYC);

    logic          tick;
    logic [PW-1:0] pending;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_next;
    to_state_e     state;

    ref_tick_gen #(
        .PERIOD (REF_PERIOD)
    ) u_tick_gen (
        .clk_sys (CLK_FSB),
        .rst_n   (nRES),
        .tick    (tick)
    );

    // Refresh debt: ticks add, acks retire; a simultaneous tick and ack cancel.
    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            pending <= '0;
        end else if (tick && !RefAck) begin
            if (pending != PEND_MAX) begin
                pending <= pending + 1'b1;
            end
        end else if (RefAck && !tick) begin
            if (pending != '0) begin
                pending <= pending - 1'b1;
            end
        end
    end

    // Request flags lag the pending counter by one cycle.
    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            RefReq    <= 1'b0;
            RefUrgent <= 1'b0;
        end else begin
            RefReq    <= (pending != '0);
            RefUrgent <= (pending >= PEND_URG);
        end
    end

`ifdef REF_OVERFLOW_EN
    // Sticky record of a tick dropped because the debt counter was full.
    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            RefOverflow <= 1'b0;
        end else if (tick && !RefAck && (pending == PEND_MAX)) begin
            RefOverflow <= 1'b1;
        end
    end
`endif

    // Bus-cycle length, saturating at TOB_CYC; any idle cycle restarts it.
    always_comb begin
        to_cnt_next = to_cnt;
        if (!ASActive) begin
            to_cnt_next = '0;
        end else if (to_cnt != TOB_LIM) begin
            to_cnt_next = to_cnt + 1'b1;
        end
    end

    // Timeout FSM with registered TimeoutA/TimeoutB.
    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            to_cnt   <= '0;
            TimeoutA <= 1'b0;
            TimeoutB <= 1'b0;
        end else begin
            to_cnt <= to_cnt_next;
            if (!ASActive) begin
                state    <= IDLE;
                TimeoutA <= 1'b0;
                TimeoutB <= 1'b0;
            end else begin
                case (state)
                    IDLE, COUNT: begin
                        if (to_cnt_next >= TOB_LIM) begin
                            state    <= EXPB;
                            TimeoutA <= 1'b1;
                            TimeoutB <= 1'b1;
                        end else if (to_cnt_next >= TOA_LIM) begin
                            state    <= EXPA;
                            TimeoutA <= 1'b1;
                            TimeoutB <= 1'b0;
                        end else begin
                            state    <= COUNT;
                            TimeoutA <= 1'b0;
                            TimeoutB <= 1'b0;
                        end
                    end
                    EXPA: begin
                        if (to_cnt_next >= TOB_LIM) begin
                            state    <= EXPB;
                            TimeoutA <= 1'b1;
                            TimeoutB <= 1'b1;
                        end
                    end
                    EXPB: begin
                        state    <= EXPB;
                        TimeoutA <= 1'b1;
                        TimeoutB <= 1'b1;
                    end
                    default: begin
                        state    <= IDLE;
                        TimeoutA <= 1'b0;
                        TimeoutB <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
